// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and elaboration helpers for the pipelined adder/subtractor.
//   op_e         : operation select carried on the 'sub' input (add / subtract)
//   stage_ctl_t  : per-stage control payload (valid bit + carry into next slice)
//   slice_width  : bits handled per pipeline stage
//   slices_fit   : legality of an (N, STAGES) pair
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int N_DEFAULT      = 32;
  localparam int STAGES_DEFAULT = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Control half of a stage payload; the operand and partial-sum halves
  // have stage-dependent widths and live next to it in each stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  function automatic bit slices_fit(input int n, input int stages);
    return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Combinational W-bit ripple-carry adder built from 1-bit full adders.
//   a, b      : W-bit operands
//   c_in      : carry into bit 0
//   sum       : W-bit sum
//   c_out     : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (used for signed-overflow detection)
// -----------------------------------------------------------------------------
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [W:0] carry;

  // NOTE: blocking assignments in combinational logic, so each bit sees the
  // carry produced by the bit below it within the same evaluation.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out    = carry[W];
  assign c_msb_in = carry[W-1];

endmodule

// File: rtl/adder_pipelined.sv
// -----------------------------------------------------------------------------
// adder_pipelined
// N-bit adder/subtractor split into STAGES ripple slices with one register
// stage per slice, valid/ready handshake on both sides (bubble-collapsing).
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid / in_ready     : input handshake for a, b, sub, c_in
//   a, b                    : N-bit operands
//   sub                     : 0 = a+b+c_in, 1 = a-b (c_in ignored)
//   c_in                    : carry-in for add mode
//   out_valid / out_ready   : output handshake for sum, c_out, overflow
//   sum                     : N-bit result (modulo 2^N)
//   c_out                   : carry out of MSB (sub: 1 = no borrow)
//   overflow                : signed overflow
// -----------------------------------------------------------------------------
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int SLICE = slice_width(N, STAGES);

  if (!slices_fit(N, STAGES)) begin : g_bad_cfg
    $error("adder_pipelined: N=%0d cannot be split into STAGES=%0d equal slices", N, STAGES);
  end

  // Subtraction is a + ~b + 1; stage 0 folds the inversion and forced carry.
  op_e          op;
  logic [N-1:0] b_eff;
  logic         carry_first;

  assign op          = op_e'(sub);
  assign b_eff       = (op == OP_SUB) ? ~b : b;
  assign carry_first = (op == OP_SUB) ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = k * SLICE;  // first bit computed here
    localparam int TOP = LO + SLICE; // result bits known after this stage

    // Operand bits not yet consumed by earlier stages.
    logic [N-1:LO]    op_a;
    logic [N-1:LO]    op_b;
    logic             carry_in;
    logic             valid_in;
    logic             ready;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [TOP-1:0]   sum_new;

    stage_ctl_t       ctl_d, ctl_q;
    logic [TOP-1:0]   sum_d, sum_q;
    logic             stage_valid;
    logic             stage_carry;

    assign stage_valid = ctl_q.valid;
    assign stage_carry = ctl_q.carry;

    if (k == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = b_eff;
      assign carry_in = carry_first;
      assign valid_in = in_valid;
      assign sum_new  = slice_sum;
    end else begin : g_body
      assign op_a     = g_st[k-1].g_ops.a_q;
      assign op_b     = g_st[k-1].g_ops.b_q;
      assign carry_in = g_st[k-1].stage_carry;
      assign valid_in = g_st[k-1].stage_valid;
      assign sum_new  = {slice_sum, g_st[k-1].sum_q};
    end

    // An empty stage always accepts, which squeezes bubbles out under a stall.
    if (k == STAGES - 1) begin : g_rdy_last
      assign ready = !stage_valid | out_ready;
    end else begin : g_rdy_mid
      assign ready = !stage_valid | g_st[k+1].ready;
    end

    adder_slice #(.W(SLICE)) u_slice (
      .a        (op_a[LO +: SLICE]),
      .b        (op_b[LO +: SLICE]),
      .c_in     (carry_in),
      .sum      (slice_sum),
      .c_out    (slice_cout),
      .c_msb_in (slice_cmsb)
    );

    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
      ctl_d = ctl_q;
      sum_d = sum_q;
      if (ready) begin
        ctl_d.valid = valid_in;
        ctl_d.carry = slice_cout;
        sum_d       = sum_new;
      end
    end

    // NOTE: non-blocking assignments for state, so all stages sample their
    // inputs from before the edge and the pipeline shifts by exactly one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    // Upper operand bits still to be added by later stages.
    if (k < STAGES - 1) begin : g_ops
      logic [N-1:TOP] a_d, a_q;
      logic [N-1:TOP] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (ready) begin
          a_d = op_a[N-1:TOP];
          b_d = op_b[N-1:TOP];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Only the top slice's carry into the MSB matters (for overflow).
    if (k == STAGES - 1) begin : g_tail
      logic cmsb_d, cmsb_q;

      always_comb begin
        cmsb_d = cmsb_q;
        if (ready) cmsb_d = slice_cmsb;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cmsb_q <= 1'b0;
        else     cmsb_q <= cmsb_d;
      end
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = slice_cmsb;
    end
  end

  assign in_ready  = g_st[0].ready;
  assign out_valid = g_st[STAGES-1].stage_valid;
  assign sum       = g_st[STAGES-1].sum_q;
  assign c_out     = g_st[STAGES-1].stage_carry;
  assign overflow  = g_st[STAGES-1].stage_carry ^ g_st[STAGES-1].g_tail.cmsb_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// -----------------------------------------------------------------------------
// tb_adder_pipelined
// Self-checking bench: main instance N=32/STAGES=4 with a queue scoreboard,
// plus N=8/STAGES=8 and N=8/STAGES=1 instances checked cycle-by-cycle.
// -----------------------------------------------------------------------------
module tb_adder_pipelined;

  localparam int N      = 32;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  logic         in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, overflow;
  logic [N-1:0] a, b, sum;

  adder_pipelined #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  // Small-width instances share one stimulus stream
  logic       s_valid, s_sub, s_cin, s_out_ready;
  logic [7:0] s_a, s_b;
  logic       s8_in_ready, s8_out_valid, s8_c_out, s8_ovf;
  logic [7:0] s8_sum;
  logic       s1_in_ready, s1_out_valid, s1_c_out, s1_ovf;
  logic [7:0] s1_sum;

  adder_pipelined #(.N(8), .STAGES(8)) dut_n8_s8 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s8_in_ready),
    .a(s_a), .b(s_b), .sub(s_sub), .c_in(s_cin),
    .out_valid(s8_out_valid), .out_ready(s_out_ready),
    .sum(s8_sum), .c_out(s8_c_out), .overflow(s8_ovf)
  );

  adder_pipelined #(.N(8), .STAGES(1)) dut_n8_s1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s1_in_ready),
    .a(s_a), .b(s_b), .sub(s_sub), .c_in(s_cin),
    .out_valid(s1_out_valid), .out_ready(s_out_ready),
    .sum(s1_sum), .c_out(s1_c_out), .overflow(s1_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  // Returns {overflow, c_out, sum[63:0]}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic op_sub, input logic cin);
    logic [63:0] mask, raw;
    logic        co, ov;
    longint      sx, sy, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sx   = x[w-1] ? longint'(x) - 2 * lim : longint'(x);
    sy   = y[w-1] ? longint'(y) - 2 * lim : longint'(y);
    if (op_sub) begin
      raw = x - y;
      co  = (x >= y);
      sr  = sx - sy;
    end else begin
      raw = x + y + 64'(cin);
      co  = raw[w];
      sr  = sx + sy + longint'(cin);
    end
    ov = (sr >= lim) || (sr < -lim);
    return {ov, co, raw & mask};
  endfunction

  // ---------------------------------------------------------------------------
  // Main-instance scoreboard: evaluated mid-cycle for the coming edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
  } op_t;

  op_t          exp_q[$];
  logic [N-1:0] retired_q[$];
  logic         stall_prev = 1'b0;
  logic [N+1:0] held;

  always @(negedge clk) begin
    op_t         o;
    logic [65:0] r;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_vs_full", 64'(in_ready), 64'(!(exp_q.size() == STAGES && !out_ready)));
      if (exp_q.size() == 0) check("out_valid_when_empty", 64'(out_valid), 64'd0);
      if (stall_prev) check("held_output_stable", 64'({sum, c_out, overflow}), 64'(held));
      if (out_valid && out_ready) begin
        check("retire_has_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          o = exp_q.pop_front();
          r = ref_op(N, 64'(o.a), 64'(o.b), o.sub, o.cin);
          check("sum", 64'(sum), 64'(r[N-1:0]));
          check("c_out", 64'(c_out), 64'(r[64]));
          check("overflow", 64'(overflow), 64'(r[65]));
          retired_q.push_back(sum);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {sum, c_out, overflow};
      if (in_valid && in_ready) exp_q.push_back('{a: a, b: b, sub: sub, cin: c_in});
    end
  end

  // ---------------------------------------------------------------------------
  // Small instances: output in cycle t must be the op presented in t-STAGES.
  // ---------------------------------------------------------------------------
  logic        small_on = 1'b0;
  logic [18:0] hist [0:4095]; // {valid, sub, cin, a, b}
  int          sc = 0;

  task automatic check_small(input string tag, input int lag, input logic ov_valid,
                             input logic [7:0] osum, input logic oco, input logic oovf);
    logic [18:0] h;
    logic [65:0] r;
    h = (sc >= lag) ? hist[sc - lag] : '0;
    check({tag, "_out_valid"}, 64'(ov_valid), 64'(h[18]));
    if (h[18]) begin
      r = ref_op(8, 64'(h[15:8]), 64'(h[7:0]), h[17], h[16]);
      check({tag, "_sum"}, 64'(osum), 64'(r[7:0]));
      check({tag, "_c_out"}, 64'(oco), 64'(r[64]));
      check({tag, "_overflow"}, 64'(oovf), 64'(r[65]));
    end
  endtask

  always @(negedge clk) begin
    if (small_on && !rst) begin
      hist[sc] = {s_valid, s_sub, s_cin, s_a, s_b};
      check("n8s8_in_ready", 64'(s8_in_ready), 64'd1);
      check("n8s1_in_ready", 64'(s1_in_ready), 64'd1);
      check_small("n8s8", 8, s8_out_valid, s8_sum, s8_c_out, s8_ovf);
      check_small("n8s1", 1, s1_out_valid, s1_sum, s1_c_out, s1_ovf);
      sc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed single op: checks latency and the expected result.
  // ---------------------------------------------------------------------------
  task automatic run_single(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_op,
                            input logic tsub, input logic tcin,
                            input logic [N-1:0] es, input logic eco, input logic eov);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb_op; sub = tsub; c_in = tcin;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
      end
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 64'(lat), 64'(STAGES));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_c_out"}, 64'(c_out), 64'(eco));
    check({tag, "_overflow"}, 64'(overflow), 64'(eov));
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  initial begin
    int idx;
    int full_seen;
    bit bp_ok;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0; s_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_c_out", 64'(c_out), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_n8s8_out_valid", 64'(s8_out_valid), 64'd0);
    check("reset_n8s1_sum", 64'(s1_sum), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed arithmetic cases
    run_single("add_wrap",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("add_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("add_cin",    32'h1,         32'h2, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
    run_single("sub_borrow", 32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_ovf",    32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: 10 ops, out_ready pattern 0,0,1
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    retired_q.delete();
    idx = 0;
    full_seen = 0;
    for (int cyc = 0; cyc < 300 && (idx < 10 || retired_q.size() < 10); cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc % 3 == 2);
      if (idx < 10) begin
        in_valid = 1'b1; a = N'(idx + 1); b = N'(100 * (idx + 1)); sub = 1'b0; c_in = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready) full_seen++;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_full_reached", 64'(full_seen > 0), 64'd1);
    check("bp_retired_count", 64'(retired_q.size()), 64'd10);
    bp_ok = 1'b1;
    for (int i = 0; i < retired_q.size() && i < 10; i++)
      if (retired_q[i] !== N'(101 * (i + 1))) bp_ok = 1'b0;
    check("bp_order_values", 64'(bp_ok), 64'd1);

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      sub = 1'($urandom); c_in = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;
    check("random_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight: 3 ops in flight, none may reappear
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom | 32'h1; b = $urandom; sub = 1'(i); c_in = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_sum_zero", 64'(sum), 64'd0);
    check("midreset_c_out_zero", 64'(c_out), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_reset_quiet", 64'(out_valid), 64'd0);
    end
    run_single("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Small configurations at full throughput
    @(posedge clk); #1;
    small_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(0, 7) != 0);
      s_a = pick8(); s_b = pick8();
      s_sub = 1'($urandom); s_cin = 1'($urandom);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    small_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
